// File: rtl/pong_pkg.sv
// Types and screen geometry shared by the pong physics stage and the ball renderer.
package pong_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef logic [8:0] xcoord_t;
  typedef logic [7:0] ycoord_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ERASE = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } render_state_t;

  // Sums are one bit wider than the screen coordinates so an overflow clips instead of wrapping.
  function automatic logic on_screen(input logic [9:0] col, input logic [8:0] row);
    return (col < 10'(SCREEN_W)) && (row < 9'(SCREEN_H));
  endfunction

endpackage

// File: rtl/ball_renderer_rect_scan.sv
// Row-major rectangle scanner: presents the pixel offset to emit next and advances on step.
// The counters wrap to (0,0) after the last pixel, so back-to-back passes need no restart cycle.
module rect_scan
  import pong_pkg::*;
(
  input  logic    i_clock,
  input  logic    i_reset,
  input  logic    i_start,
  input  logic    i_step,
  input  xcoord_t i_width,
  input  ycoord_t i_height,
  output xcoord_t o_cx,
  output ycoord_t o_cy,
  output logic    o_last
);

  xcoord_t r_cx;
  ycoord_t r_cy;
  logic    w_row_end;

  assign o_cx      = i_start ? '0 : r_cx;
  assign o_cy      = i_start ? '0 : r_cy;
  assign w_row_end = (o_cx == i_width - 9'd1);
  assign o_last    = w_row_end && (o_cy == i_height - 8'd1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_step) begin
      if (o_last) begin
        r_cx <= '0;
        r_cy <= '0;
      end else if (w_row_end) begin
        r_cx <= '0;
        r_cy <= o_cy + 8'd1;
      end else begin
        r_cx <= o_cx + 9'd1;
      end
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// Turns ball positions from the physics stage into VGA pixel writes: erase old square, draw new.
// Define SCREEN_CLEAR_EN to sweep the whole screen with the background colour after reset.
module ball_renderer
  import pong_pkg::*;
#(
  parameter int      BALL_SIZE   = 4,
  parameter colour_t BALL_COLOUR = 3'b111,
  parameter colour_t BG_COLOUR   = 3'b000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          set,
  input  xcoord_t       x,
  input  ycoord_t       y,
  output logic          ready,
  output logic          done,
  output xcoord_t       vga_x,
  output ycoord_t       vga_y,
  output colour_t       colour,
  output logic          plot,
  output render_state_t dbg_state
);

  // Handshake: set is a one-cycle pulse; x/y are sampled only in that cycle. A pulse while busy
  // is parked in a 1-deep pending slot (newest wins); done pulses once per finished update.

  render_state_t r_state, w_next, w_kind;
  xcoord_t r_new_x, r_old_x, r_pend_x, r_vga_x, w_src_x, w_base_x, w_scan_w, w_cx;
  ycoord_t r_new_y, r_old_y, r_pend_y, r_vga_y, w_src_y, w_base_y, w_scan_h, w_cy;
  colour_t r_colour, w_colour;
  logic    r_have_old, r_pend_v, r_last, r_ready, r_done, r_plot;
  logic    w_start, w_emit, w_load_new, w_pend_v_next, w_ready_next, w_scan_last;
  logic [9:0] w_col;
  logic [8:0] w_row;

  rect_scan u_scan (
    .i_clock (clock),
    .i_reset (reset),
    .i_start (w_start),
    .i_step  (w_emit),
    .i_width (w_scan_w),
    .i_height(w_scan_h),
    .o_cx    (w_cx),
    .o_cy    (w_cy),
    .o_last  (w_scan_last)
  );

  // r_last marks that the pixel currently on the outputs closed a pass.
  always_comb begin
    w_next     = r_state;
    w_kind     = ST_DRAW;
    w_start    = 1'b0;
    w_emit     = 1'b0;
    w_load_new = 1'b0;
    w_src_x    = x;
    w_src_y    = y;
    case (r_state)
      ST_IDLE: begin
        if (set || r_pend_v) begin
          w_load_new = 1'b1;
          w_start    = 1'b1;
          w_emit     = 1'b1;
          if (!set) begin
            w_src_x = r_pend_x;
            w_src_y = r_pend_y;
          end
          w_kind = r_have_old ? ST_ERASE : ST_DRAW;
          w_next = w_kind;
        end
      end
      ST_ERASE: begin
        w_emit = 1'b1;
        if (r_last) begin
          w_start = 1'b1;
          w_kind  = ST_DRAW;
          w_next  = ST_DRAW;
        end else begin
          w_kind = ST_ERASE;
        end
      end
      ST_DRAW: begin
        if (r_last) w_next = ST_DONE;
        else        w_emit = 1'b1;
      end
      ST_DONE: begin
        if (r_pend_v) begin
          w_load_new = 1'b1;
          w_start    = 1'b1;
          w_emit     = 1'b1;
          w_src_x    = r_pend_x;
          w_src_y    = r_pend_y;
          w_kind     = ST_ERASE;
          w_next     = ST_ERASE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CLEAR: begin
`ifdef SCREEN_CLEAR_EN
        if (r_last) begin
          w_next = ST_IDLE;
        end else begin
          w_emit = 1'b1;
          w_kind = ST_CLEAR;
        end
`else
        w_next = ST_IDLE;
`endif
      end
      default: w_next = ST_IDLE;
    endcase

    w_pend_v_next = r_pend_v;
    if (set && r_state != ST_IDLE) w_pend_v_next = 1'b1;
    else if (w_load_new)           w_pend_v_next = 1'b0;
    w_ready_next = (w_next == ST_IDLE) && !w_pend_v_next;
  end

  always_comb begin
    w_base_x = '0;
    w_base_y = '0;
    w_colour = BG_COLOUR;
    w_scan_w = 9'(BALL_SIZE);
    w_scan_h = 8'(BALL_SIZE);
    case (w_kind)
      ST_ERASE: begin
        w_base_x = r_old_x;
        w_base_y = r_old_y;
      end
      ST_DRAW: begin
        w_base_x = w_load_new ? w_src_x : r_new_x;
        w_base_y = w_load_new ? w_src_y : r_new_y;
        w_colour = BALL_COLOUR;
      end
      ST_CLEAR: begin
        w_scan_w = 9'(SCREEN_W);
        w_scan_h = 8'(SCREEN_H);
      end
      default: ;
    endcase
    w_col = {1'b0, w_base_x} + {1'b0, w_cx};
    w_row = {1'b0, w_base_y} + {1'b0, w_cy};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
`ifdef SCREEN_CLEAR_EN
      r_state <= ST_CLEAR;
      r_ready <= 1'b0;
`else
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
`endif
      r_new_x    <= '0;
      r_new_y    <= '0;
      r_old_x    <= '0;
      r_old_y    <= '0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_pend_v   <= 1'b0;
      r_have_old <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_plot     <= 1'b0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
      r_colour   <= '0;
    end else begin
      r_state  <= w_next;
      r_ready  <= w_ready_next;
      r_pend_v <= w_pend_v_next;
      r_plot   <= w_emit && on_screen(w_col, w_row);
      r_last   <= w_emit && w_scan_last;
      r_done   <= (r_state == ST_DRAW) && r_last;
      if (w_emit) begin
        r_vga_x  <= w_col[8:0];
        r_vga_y  <= w_row[7:0];
        r_colour <= w_colour;
      end
      if (set && r_state != ST_IDLE) begin
        r_pend_x <= x;
        r_pend_y <= y;
      end
      if (w_load_new) begin
        r_new_x <= w_src_x;
        r_new_y <= w_src_y;
      end
      // The finished square becomes the one to erase on the next update.
      if (r_state == ST_DRAW && r_last) begin
        r_old_x    <= r_new_x;
        r_old_y    <= r_new_y;
        r_have_old <= 1'b1;
      end
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign plot      = r_plot;
  assign vga_x     = r_vga_x;
  assign vga_y     = r_vga_y;
  assign colour    = r_colour;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: vector table, randomized updates and corner sequences.
module tb_ball_renderer;
  import pong_pkg::*;

  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          set = 1'b0;
  xcoord_t       x = '0;
  ycoord_t       y = '0;
  logic          ready, done, plot;
  xcoord_t       vga_x;
  ycoord_t       vga_y;
  colour_t       colour;
  render_state_t dbg_state;

  ball_renderer #(.BALL_SIZE(S), .BALL_COLOUR(3'b111), .BG_COLOUR(3'b000)) dut (
    .clock(clk), .reset(rst_n), .set(set), .x(x), .y(y),
    .ready(ready), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .plot(plot), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_plot = 0;
  logic [19:0] exp_q[$];

  // reference model state: where the square currently on screen sits
  bit m_have_old = 1'b0;
  int m_old_x = 0;
  int m_old_y = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void push_square(input int bx, input int by, input int col);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        if (bx + c < 320 && by + r < 240)
          exp_q.push_back({9'(bx + c), 8'(by + r), 3'(col)});
  endfunction

  function automatic int model_update(input int nx, input int ny);
    int lat;
    lat = m_have_old ? 2 * S * S + 1 : S * S + 1;
    if (m_have_old) push_square(m_old_x, m_old_y, 0);
    push_square(nx, ny, 7);
    m_old_x = nx;
    m_old_y = ny;
    m_have_old = 1'b1;
    return lat;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [19:0] got, want;
    if (plot === 1'b1) begin
      n_plot++;
      got = {vga_x, vga_y, colour};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_plot: got x=%0d y=%0d c=%0d required no plot", vga_x, vga_y, colour);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                   vga_x, vga_y, colour, want[19:11], want[10:3], want[2:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    set = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_have_old = 1'b0;
`ifdef SCREEN_CLEAR_EN
    for (int r = 0; r < 240; r++)
      for (int c = 0; c < 320; c++)
        exp_q.push_back({9'(c), 8'(r), 3'd0});
`endif
    rst_n = 1'b1;
  endtask

  task automatic pulse_set(input int px, input int py);
    set = 1'b1;
    x = 9'(px);
    y = 8'(py);
    @(negedge clk);
    set = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got ready=%0b required 1 within %0d cycles", ready, budget);
    end
  endtask

  // Called at the sample point of cycle 'start'; returns the cycle in which done was seen, or -1.
  task automatic wait_done(input int start, input int budget, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done required done within %0d cycles", budget);
      cyc = -1;
    end
  endtask

  // exp_plots/exp_lat < 0 means "take it from the reference model"
  task automatic do_update(input string tag, input int px, input int py,
                           input int exp_plots, input int exp_lat);
    int lat, cyc, p0;
    wait_ready(80000);
    p0 = n_plot;
    lat = model_update(px, py);
    pulse_set(px, py);
    wait_done(1, 200, cyc);
    check({tag, "_done_cycle"}, cyc, (exp_lat < 0) ? lat : exp_lat);
    check({tag, "_ready_in_done"}, int'(ready), 0);
    @(negedge clk);
    check({tag, "_ready_after"}, int'(ready), 1);
    check({tag, "_done_width"}, int'(done), 0);
    if (exp_plots >= 0) check({tag, "_plots"}, n_plot - p0, exp_plots);
  endtask

  typedef struct {
    bit rst;
    int x;
    int y;
    int plots;
    int lat;
  } vec_t;

  initial begin : main
    vec_t vecs[7];
    int cyc, lat, rx, ry;

    vecs[0] = '{1'b0, 100, 50,  16, 17};
    vecs[1] = '{1'b0, 104, 52,  32, 33};
    vecs[2] = '{1'b0, 318, 238, 20, 33};
    vecs[3] = '{1'b0, 0,   0,   20, 33};
    vecs[4] = '{1'b0, 319, 0,   20, 33};
    vecs[5] = '{1'b0, 5,   239, 8,  33};
    vecs[6] = '{1'b1, 318, 238, 4,  17};

    // reset state
    @(negedge clk);
`ifdef SCREEN_CLEAR_EN
    check("rst_ready", int'(ready), 0);
`else
    check("rst_ready", int'(ready), 1);
`endif
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_colour", int'(colour), 0);
    do_reset();

`ifdef SCREEN_CLEAR_EN
    begin : clear_sweep
      int ready_hi;
      ready_hi = 0;
      for (int c = 1; c <= 76800; c++) begin
        @(negedge clk);
        if (ready === 1'b1) ready_hi++;
      end
      check("clear_ready_low", ready_hi, 0);
      @(negedge clk);
      check("clear_ready_cycle", int'(ready), 1);
      check("clear_all_plotted", exp_q.size(), 0);
    end
`endif

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      do_update($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].plots, vecs[i].lat);
    end

    // randomized updates, some hugging the right/bottom edges
    for (int i = 0; i < 16; i++) begin
      rx = (i % 4 == 3) ? $urandom_range(310, 319) : $urandom_range(0, 319);
      ry = (i % 4 == 2) ? $urandom_range(230, 239) : $urandom_range(0, 239);
      do_update($sformatf("rnd%0d", i), rx, ry, -1, -1);
    end

    // two sets while busy: only the newest is rendered
    wait_ready(80000);
    lat = model_update(150, 100);
    pulse_set(150, 100);
    repeat (3) @(negedge clk);
    pulse_set(10, 10);
    repeat (3) @(negedge clk);
    pulse_set(20, 20);
    void'(model_update(20, 20));
    wait_done(9, 200, cyc);
    check("pend_first_done", cyc, lat);
    @(negedge clk);
    check("pend_busy_ready", int'(ready), 0);
    wait_done(1, 200, cyc);
    check("pend_second_done", cyc, 2 * S * S + 1);
    @(negedge clk);
    check("pend_ready_after", int'(ready), 1);

    // set landing in the done cycle is not lost
    wait_ready(80000);
    void'(model_update(60, 70));
    pulse_set(60, 70);
    wait_done(1, 200, cyc);
    check("sd_first_done", cyc, 2 * S * S + 1);
    void'(model_update(80, 90));
    pulse_set(80, 90);
    wait_done(1, 200, cyc);
    check("sd_second_seen", int'(cyc > 0), 1);
    @(negedge clk);
    check("sd_ready_after", int'(ready), 1);
    check("sd_queue_drained", exp_q.size(), 0);

    // reset in the middle of DRAW: outputs drop at once, next update has no erase pass
    wait_ready(80000);
    void'(model_update(200, 100));
    pulse_set(200, 100);
    repeat (19) @(negedge clk);
    check("mr_plot_before", int'(plot), 1);
    check("mr_colour_before", int'(colour), 7);
    #2 rst_n = 1'b0;
    #1;
    check("mr_plot_async", int'(plot), 0);
    check("mr_done_async", int'(done), 0);
    @(negedge clk);
    do_reset();
    do_update("mr_next", 30, 40, 16, 17);

    check("leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
